// File: rtl/spi_lcd_writer.sv
// spi_lcd_writer: write-only SPI master for LCD panels with a
// small command FIFO and optional chip-select bursts.
module spi_lcd_writer #(
   parameter int DATA_W     = 8,
   parameter int CLK_DIV    = 2,
   parameter int FIFO_DEPTH = 4,
   parameter bit CPOL       = 1'b0,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit BURST      = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en_i,
   input  logic                          wr_dc_i,
   input  logic [DATA_W-1:0]             wr_data_i,
   output logic                          wr_ready_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          overflow_o,
   output logic                          lcd_cs_o,
   output logic                          lcd_dc_o,
   output logic                          lcd_scl_o,
   output logic                          lcd_sda_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(DATA_W);
   localparam logic [DW-1:0] DIV_LD = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LD = BW'(DATA_W - 1);
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] ONE = (AW+1)'(1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOW  = 3'd1;
   localparam logic [2:0] S_HIGH = 3'd2;
   localparam logic [2:0] S_HOLD = 3'd3;
   localparam logic [2:0] S_GAP  = 3'd4;

   logic [DATA_W:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       level_nxt;
   logic              fifo_ne_q;
   logic              push;
   logic              pop;
   logic [DATA_W:0]   head;
   logic              head_bit;

   logic [2:0]        state;
   logic [DW-1:0]     div_cnt;
   logic [BW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shnxt;
   logic              div_end;
   logic              last_bit;
   logic              burst_pop;

   assign push      = wr_en_i && wr_ready_o;
   assign head      = mem[rd_ptr];
   assign head_bit  = MSB_FIRST ? head[DATA_W-1] : head[0];
   assign shnxt     = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
   assign div_end   = (div_cnt == '0);
   assign last_bit  = (bit_cnt == '0);
   assign burst_pop = BURST && (fifo_level_o != '0);

   // fifo_ne_q lags the level by one edge; IDLE only ever follows
   // states that never pop, so a set flag implies a stored word.
   assign pop = ((state == S_IDLE) && fifo_ne_q) ||
                ((state == S_HIGH) && div_end &&
                 last_bit && burst_pop);

   always_comb begin
      level_nxt = fifo_level_o;
      if (push && !pop)
         level_nxt = fifo_level_o + ONE;
      else if (pop && !push)
         level_nxt = fifo_level_o - ONE;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {wr_dc_i, wr_data_i};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_level_o <= '0;
         wr_ready_o   <= 1'b1;
         overflow_o   <= 1'b0;
         fifo_ne_q    <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         fifo_level_o <= level_nxt;
         wr_ready_o   <= (level_nxt != FULL);
         fifo_ne_q    <= (fifo_level_o != '0);
         if (wr_en_i && !wr_ready_o)
            overflow_o <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         lcd_cs_o  <= 1'b1;
         lcd_dc_o  <= 1'b0;
         lcd_scl_o <= CPOL;
         lcd_sda_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (!div_end)
            div_cnt <= div_cnt - 1'b1;
         unique case (state)
            S_IDLE: begin
               if (fifo_ne_q) begin
                  state     <= S_LOW;
                  busy_o    <= 1'b1;
                  lcd_cs_o  <= 1'b0;
                  lcd_scl_o <= CPOL;
                  div_cnt   <= DIV_LD;
                  bit_cnt   <= BIT_LD;
                  shreg     <= head[DATA_W-1:0];
                  lcd_dc_o  <= head[DATA_W];
                  lcd_sda_o <= head_bit;
               end
            end
            S_LOW: begin
               if (div_end) begin
                  state     <= S_HIGH;
                  lcd_scl_o <= ~CPOL;
                  div_cnt   <= DIV_LD;
               end
            end
            S_HIGH: begin
               if (div_end) begin
                  lcd_scl_o <= CPOL;
                  div_cnt   <= DIV_LD;
                  if (!last_bit) begin
                     state     <= S_LOW;
                     bit_cnt   <= bit_cnt - 1'b1;
                     shreg     <= shnxt;
                     lcd_sda_o <= MSB_FIRST ? shnxt[DATA_W-1]
                                            : shnxt[0];
                  end else begin
                     done_o <= 1'b1;
                     if (burst_pop) begin
                        state     <= S_LOW;
                        bit_cnt   <= BIT_LD;
                        shreg     <= head[DATA_W-1:0];
                        lcd_dc_o  <= head[DATA_W];
                        lcd_sda_o <= head_bit;
                     end else begin
                        state <= S_HOLD;
                     end
                  end
               end
            end
            S_HOLD: begin
               if (div_end) begin
                  state    <= S_GAP;
                  lcd_cs_o <= 1'b1;
                  div_cnt  <= DIV_LD;
               end
            end
            S_GAP: begin
               if (div_end) begin
                  state  <= S_IDLE;
                  busy_o <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_lcd_writer.sv
// tb_spi_lcd_writer: three configurations of the LCD SPI writer,
// with a serial deserializer feeding an expected-word scoreboard.
module tb_spi_lcd_writer;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   cyc;
   int   sel;

   logic       en0, dci0, en1, dci1, en2, dci2;
   logic [7:0] d0, d1;
   logic [8:0] d2;
   logic       rdy0, busy0, done0, ovf0, cs0, dc0, scl0, sda0;
   logic       rdy1, busy1, done1, ovf1, cs1, dc1, scl1, sda1;
   logic       rdy2, busy2, done2, ovf2, cs2, dc2, scl2, sda2;
   logic [2:0] lvl0, lvl1, lvl2;

   logic m_cs, m_scl, m_sda, m_dc, m_done, m_busy, m_cpol;
   logic [16:0] sb[$];

   typedef struct {
      logic       dc;
      logic [7:0] data;
      int         lvl;
      logic       rdy;
      logic       ovf;
      bit         taken;
   } vec_t;

   spi_lcd_writer u0 (
      .clk(clk), .rst(rst), .wr_en_i(en0), .wr_dc_i(dci0),
      .wr_data_i(d0), .wr_ready_o(rdy0), .fifo_level_o(lvl0),
      .busy_o(busy0), .done_o(done0), .overflow_o(ovf0),
      .lcd_cs_o(cs0), .lcd_dc_o(dc0), .lcd_scl_o(scl0),
      .lcd_sda_o(sda0));

   spi_lcd_writer #(.BURST(1'b0)) u1 (
      .clk(clk), .rst(rst), .wr_en_i(en1), .wr_dc_i(dci1),
      .wr_data_i(d1), .wr_ready_o(rdy1), .fifo_level_o(lvl1),
      .busy_o(busy1), .done_o(done1), .overflow_o(ovf1),
      .lcd_cs_o(cs1), .lcd_dc_o(dc1), .lcd_scl_o(scl1),
      .lcd_sda_o(sda1));

   spi_lcd_writer #(.DATA_W(9), .CLK_DIV(3), .CPOL(1'b1),
                    .MSB_FIRST(1'b0)) u2 (
      .clk(clk), .rst(rst), .wr_en_i(en2), .wr_dc_i(dci2),
      .wr_data_i(d2), .wr_ready_o(rdy2), .fifo_level_o(lvl2),
      .busy_o(busy2), .done_o(done2), .overflow_o(ovf2),
      .lcd_cs_o(cs2), .lcd_dc_o(dc2), .lcd_scl_o(scl2),
      .lcd_sda_o(sda2));

   always #5 clk = ~clk;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   always_comb begin
      m_cs   = cs0;
      m_scl  = scl0;
      m_sda  = sda0;
      m_dc   = dc0;
      m_done = done0;
      m_busy = busy0;
      m_cpol = 1'b0;
      if (sel == 1) begin
         m_cs   = cs1;
         m_scl  = scl1;
         m_sda  = sda1;
         m_dc   = dc1;
         m_done = done1;
         m_busy = busy1;
      end else if (sel == 2) begin
         m_cs   = cs2;
         m_scl  = scl2;
         m_sda  = sda2;
         m_dc   = dc2;
         m_done = done2;
         m_busy = busy2;
         m_cpol = 1'b1;
      end
   end

   task automatic chk(input string name, input int act,
                      input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d",
                  name, act, exp);
      end
   endtask

   // Slave model: capture sda on each idle-to-active scl edge.
   initial begin : mon
      logic        p;
      int          n;
      int          nb;
      logic [15:0] w;
      logic        d;
      logic [16:0] e;
      p = 1'b0;
      n = 0;
      w = '0;
      d = 1'b0;
      forever begin
         @(negedge clk);
         nb = (sel == 2) ? 9 : 8;
         if (rst || m_cs) begin
            n = 0;
         end else if (p == m_cpol && m_scl != m_cpol) begin
            if (n == 0)
               w = '0;
            if (sel == 2)
               w[n] = m_sda;
            else
               w = {w[14:0], m_sda};
            d = m_dc;
            n++;
            if (n == nb) begin
               n = 0;
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_extra actual=%0h required=none",
                           {d, w});
               end else begin
                  e = sb.pop_front();
                  chk("sb_word", int'({d, w}), int'(e));
               end
            end
         end
         p = m_scl;
      end
   end

   task automatic drive(input int which, input logic dc,
                        input logic [8:0] data, input bit taken);
      en0 = 1'b0;
      en1 = 1'b0;
      en2 = 1'b0;
      if (which == 0) begin
         en0 = 1'b1; dci0 = dc; d0 = data[7:0];
      end else if (which == 1) begin
         en1 = 1'b1; dci1 = dc; d1 = data[7:0];
      end else begin
         en2 = 1'b1; dci2 = dc; d2 = data;
      end
      if (taken)
         sb.push_back({dc, 7'b0, data});
      @(negedge clk);
   endtask

   task automatic release_all();
      en0 = 1'b0;
      en1 = 1'b0;
      en2 = 1'b0;
   endtask

   task automatic wait_cs_low(input int budget);
      int i;
      i = 0;
      while (m_cs && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk("cs_low_wait", int'(!m_cs), 1);
   endtask

   task automatic wait_done(input int budget);
      int i;
      i = 0;
      while (!m_done && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk("done_wait", int'(m_done), 1);
   endtask

   task automatic measure(input int words, input int budget,
                          output int rises, output int cs_rises,
                          output int dones, output int dgap,
                          output int amin, output int amax,
                          output int hmax);
      logic ps, pc;
      int   last_d, run, hrun;
      bit   started, fin;
      rises = 0; cs_rises = 0; dones = 0; dgap = -1;
      amin = 999; amax = 0; hmax = 0;
      last_d = -1; run = 0; hrun = 0;
      started = 0; fin = 0;
      ps = m_scl;
      pc = m_cs;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (m_busy)
            started = 1;
         if (m_scl != m_cpol) begin
            run++;
         end else if (run > 0) begin
            if (run < amin) amin = run;
            if (run > amax) amax = run;
            run = 0;
         end
         if (ps == m_cpol && m_scl != m_cpol)
            rises++;
         if (!pc && m_cs)
            cs_rises++;
         if (!m_cs) begin
            if (hrun > hmax) hmax = hrun;
            hrun = 0;
         end else if (started) begin
            hrun++;
         end
         if (m_done) begin
            dones++;
            if (last_d >= 0) dgap = c - last_d;
            last_d = c;
         end
         ps = m_scl;
         pc = m_cs;
         if (started && dones >= words && !m_busy) begin
            fin = 1;
            break;
         end
      end
      chk("measure_finished", int'(fin), 1);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t fill[6];
      int   t_cs, t_dn;
      int   rs, cr, dn, dg, an, ax, hm, tog;
      logic ps;
      logic exp_scl[4];

      fill[0] = '{1'b0, 8'h11, 1, 1'b1, 1'b0, 1'b1};
      fill[1] = '{1'b1, 8'h22, 2, 1'b1, 1'b0, 1'b1};
      fill[2] = '{1'b0, 8'h33, 3, 1'b1, 1'b0, 1'b1};
      fill[3] = '{1'b1, 8'h44, 4, 1'b0, 1'b0, 1'b1};
      fill[4] = '{1'b0, 8'h55, 4, 1'b0, 1'b1, 1'b0};
      fill[5] = '{1'b1, 8'h66, 4, 1'b0, 1'b1, 1'b0};
      exp_scl = '{1'b0, 1'b1, 1'b1, 1'b0};

      checks = 0;
      errors = 0;
      clk = 1'b0;
      rst = 1'b1;
      sel = 0;
      dci0 = 0; dci1 = 0; dci2 = 0;
      d0 = '0; d1 = '0; d2 = '0;
      release_all();
      repeat (3) @(negedge clk);

      chk("rst_cs", int'(cs0), 1);
      chk("rst_dc", int'(dc0), 0);
      chk("rst_scl", int'(scl0), 0);
      chk("rst_sda", int'(sda0), 0);
      chk("rst_done", int'(done0), 0);
      chk("rst_busy", int'(busy0), 0);
      chk("rst_ovf", int'(ovf0), 0);
      chk("rst_level", int'(lvl0), 0);
      chk("rst_ready", int'(rdy0), 1);
      chk("rst_scl_cpol1", int'(scl2), 1);
      chk("rst_cs_u1", int'(cs1), 1);
      rst = 1'b0;
      @(negedge clk);

      // single word, latency and timing
      drive(0, 1'b1, 9'h05A, 1);
      release_all();
      chk("t1_level", int'(lvl0), 1);
      chk("t1_cs_e0", int'(cs0), 1);
      @(negedge clk);
      chk("t1_cs_e1", int'(cs0), 1);
      @(negedge clk);
      t_cs = cyc;
      chk("t1_cs_e2", int'(cs0), 0);
      chk("t1_dc", int'(dc0), 1);
      chk("t1_busy", int'(busy0), 1);
      chk("t1_level_pop", int'(lvl0), 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t1_scl_phase", int'(scl0), int'(exp_scl[i]));
      end
      wait_done(60);
      t_dn = cyc;
      chk("t1_word_time", t_dn - t_cs, 32);
      @(negedge clk);
      chk("t1_done_pulse", int'(done0), 0);
      chk("t1_hold_cs", int'(cs0), 0);
      @(negedge clk);
      chk("t1_gap_cs", int'(cs0), 1);
      chk("t1_gap_busy", int'(busy0), 1);
      repeat (2) @(negedge clk);
      chk("t1_idle_busy", int'(busy0), 0);
      chk("t1_sb_empty", sb.size(), 0);

      // burst of two words under one cs window
      drive(0, 1'b0, 9'h02A, 1);
      drive(0, 1'b1, 9'h03C, 1);
      release_all();
      measure(2, 200, rs, cr, dn, dg, an, ax, hm);
      chk("t2_scl_pulses", rs, 16);
      chk("t2_cs_windows", cr, 1);
      chk("t2_dones", dn, 2);
      chk("t2_done_gap", dg, 32);
      chk("t2_half_min", an, 2);
      chk("t2_half_max", ax, 2);
      chk("t2_sb_empty", sb.size(), 0);

      // same pair without burst
      sel = 1;
      @(negedge clk);
      drive(1, 1'b0, 9'h02A, 1);
      drive(1, 1'b1, 9'h03C, 1);
      release_all();
      measure(2, 200, rs, cr, dn, dg, an, ax, hm);
      chk("t2b_scl_pulses", rs, 16);
      chk("t2b_cs_windows", cr, 2);
      chk("t2b_dones", dn, 2);
      chk("t2b_cs_gap_ok", int'(hm >= 2 && hm <= 3), 1);
      chk("t2b_sb_empty", sb.size(), 0);

      // overfill while a word is in flight
      sel = 0;
      @(negedge clk);
      drive(0, 1'b1, 9'h077, 1);
      release_all();
      wait_cs_low(10);
      for (int i = 0; i < 6; i++) begin
         drive(0, fill[i].dc, {1'b0, fill[i].data}, fill[i].taken);
         chk("t3_level", int'(lvl0), fill[i].lvl);
         chk("t3_ready", int'(rdy0), int'(fill[i].rdy));
         chk("t3_ovf", int'(ovf0), int'(fill[i].ovf));
      end
      release_all();
      measure(5, 400, rs, cr, dn, dg, an, ax, hm);
      chk("t3_dones", dn, 5);
      chk("t3_cs_windows", cr, 1);
      chk("t3_ovf_sticky", int'(ovf0), 1);
      chk("t3_sb_empty", sb.size(), 0);

      // reset during bit 3 with two words queued
      drive(0, 1'b0, 9'h0C3, 1);
      drive(0, 1'b1, 9'h0A1, 1);
      drive(0, 1'b0, 9'h0B2, 1);
      release_all();
      wait_cs_low(10);
      repeat (13) @(negedge clk);
      sb.delete();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t4_cs", int'(cs0), 1);
      chk("t4_scl", int'(scl0), 0);
      chk("t4_level", int'(lvl0), 0);
      chk("t4_busy", int'(busy0), 0);
      chk("t4_ovf", int'(ovf0), 0);
      chk("t4_done", int'(done0), 0);
      chk("t4_ready", int'(rdy0), 1);
      tog = 0;
      dn = 0;
      ps = scl0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (scl0 != ps) tog++;
         if (done0) dn++;
         ps = scl0;
      end
      chk("t4_no_scl", tog, 0);
      chk("t4_no_done", dn, 0);
      chk("t4_cs_idle", int'(cs0), 1);

      // CPOL=1, LSB first, 9-bit, divide by 3
      sel = 2;
      @(negedge clk);
      chk("t5_scl_idle", int'(scl2), 1);
      drive(2, 1'b1, 9'h1A5, 1);
      release_all();
      measure(1, 150, rs, cr, dn, dg, an, ax, hm);
      chk("t5_scl_pulses", rs, 9);
      chk("t5_dones", dn, 1);
      chk("t5_half_min", an, 3);
      chk("t5_half_max", ax, 3);
      chk("t5_scl_end", int'(scl2), 1);

      @(negedge clk);
      chk("final_sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
